// File: rtl/gcd_ctrl.sv
// gcd_ctrl -- control FSM for a subtract-based GCD datapath.
//
// The datapath holds a_reg/b_reg and reports lt (a_reg < b_reg) and
// eq (a_reg == b_reg). This controller loads both registers, then issues
// one subtract per cycle (larger minus smaller) until they are equal, and
// finally drives the result select for a one-cycle done pulse. A zero
// operand or a run exceeding MAX_ITER subtracts ends in a one-cycle err.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           request a run; accepted only while ready=1
//   data_A, data_B  operands, sampled with start (zero check only)
//   lt, eq          datapath compare status
//   ldA, ldB        datapath register loads
//   sel             subtract select: 0 = b-=a, 1 = a-=b
//   out             datapath result-drive select
//   strt            datapath compute enable
//   ready           idle, start accepted
//   done, err       one-cycle completion / error pulses
//   iter            subtract steps taken in the last run (saturating)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; ready=1
// LOAD   | load both datapath registers
// CALC   | one subtract per cycle until eq, or timeout at MAX_ITER
// DONE   | result valid on datapath, done pulse
// ERR    | zero operand or timeout, err pulse

module gcd_ctrl #(
    parameter int MAX_ITER = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] data_A,
    input  logic [3:0] data_B,
    input  logic       lt,
    input  logic       eq,
    output logic       ldA,
    output logic       ldB,
    output logic       sel,
    output logic       out,
    output logic       strt,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [3:0] iter
);

    // iter is 4 bits wide, so a limit above 15 could never be reached.
    localparam logic [3:0] ITER_LIM = (MAX_ITER > 15) ? 4'hF : 4'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DONE,
        S_ERR
    } state_t;

    state_t     r_state;
    logic [3:0] r_iter;
    logic       w_zero_op;
    logic       w_timeout;

    assign w_zero_op = (data_A == 4'd0) || (data_B == 4'd0);
    // Timeout is checked before a subtract is issued, so exactly
    // ITER_LIM subtracts happen before the run is abandoned.
    assign w_timeout = (r_state == S_CALC) && !eq && (r_iter == ITER_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_iter  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_zero_op) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state <= S_LOAD;
                            r_iter  <= 4'd0;
                        end
                    end
                end
                S_LOAD: r_state <= S_CALC;
                S_CALC: begin
                    if (eq) begin
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                    end else if (r_iter != 4'hF) begin
                        r_iter <= r_iter + 4'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode, except CALC where the subtract direction and result
    // select follow the live datapath compare.
    always_comb begin
        ldA   = 1'b0;
        ldB   = 1'b0;
        sel   = 1'b0;
        out   = 1'b0;
        strt  = 1'b0;
        ready = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        case (r_state)
            S_IDLE: ready = 1'b1;
            S_LOAD: begin
                ldA = 1'b1;
                ldB = 1'b1;
            end
            S_CALC: begin
                strt = !w_timeout;
                out  = eq;
                sel  = !eq && !lt && !w_timeout;
            end
            S_DONE: begin
                strt = 1'b1;
                out  = 1'b1;
                done = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign iter = r_iter;

endmodule

// File: tb/tb_gcd_ctrl.sv
module tb_gcd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] data_A, data_B;
    logic       lt, eq;
    logic       ldA, ldB, sel, out, strt, ready, done, err;
    logic [3:0] iter;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gcd_ctrl #(.MAX_ITER(15)) dut (
        .clk(clk), .rst(rst), .start(start), .data_A(data_A), .data_B(data_B),
        .lt(lt), .eq(eq), .ldA(ldA), .ldB(ldB), .sel(sel), .out(out),
        .strt(strt), .ready(ready), .done(done), .err(err), .iter(iter)
    );

    // Datapath model: registers, compare, subtract. force_lt overrides the
    // compare so the controller can be driven into its timeout.
    logic [3:0] a_reg = 4'd0, b_reg = 4'd0;
    logic       force_lt = 1'b0;
    assign lt = force_lt ? 1'b1 : (a_reg < b_reg);
    assign eq = force_lt ? 1'b0 : (a_reg == b_reg);

    always @(posedge clk) begin
        if (ldA) a_reg <= data_A;
        if (ldB) b_reg <= data_B;
        if (strt && !out) begin
            if (sel) a_reg <= a_reg - b_reg;
            else     b_reg <= b_reg - a_reg;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: Euclid by repeated subtraction, at most 15 steps.
    // term: 1 = done, 2 = err. lat counted in cycles after the accept edge.
    function automatic void ref_gcd(input int a_in, input int b_in, output int term,
                                    output int lat, output int g, output int n,
                                    output logic [15:0] seq);
        int a = a_in;
        int b = b_in;
        seq = 16'd0;
        n   = 0;
        g   = 0;
        if (a == 0 || b == 0) begin
            term = 2;
            lat  = 1;
        end else begin
            while (a != b && n < 15) begin
                if (a > b) begin
                    seq[n] = 1'b1;
                    a = a - b;
                end else begin
                    b = b - a;
                end
                n++;
            end
            term = (a == b) ? 1 : 2;
            g    = (a == b) ? a : 0;
            lat  = 3 + n;
        end
    endfunction

    // Issue one start, then observe up to 40 cycles. inj>0 re-asserts start
    // (with zero operands) in that cycle to check it is ignored mid-run.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int inj,
                          output int term, output int lat, output int gcdv,
                          output int nsub, output logic [15:0] selseq,
                          output logic inv_bad, output logic rdy_after);
        @(negedge clk);
        data_A = a;
        data_B = b;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        term = 0; lat = 0; gcdv = 0; nsub = 0; selseq = 16'd0; inv_bad = 1'b0;
        for (int c = 1; c <= 40 && term == 0; c++) begin
            @(negedge clk);
            if (c == inj) begin
                data_A = 4'd0;
                data_B = 4'd0;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if ((done && err) || ((ldA || ldB) && strt)) inv_bad = 1'b1;
            if (strt && !out) begin
                if (nsub < 16) selseq[nsub] = sel;
                nsub++;
            end
            if (done) begin
                term = 1;
                lat  = c;
                gcdv = a_reg;
            end else if (err) begin
                term = 2;
                lat  = c;
            end
        end
        start = 1'b0;
        @(negedge clk);
        rdy_after = ready && !done && !err;
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        int          term;
        int          lat;
        int          gcd;
        int          it;     // -1: iter must keep its previous value
        logic [15:0] sel_seq;
    } vec_t;

    vec_t vecs[7];
    int   exp_iter_hold = 0;

    task automatic check_run(input string tag, input int e_term, input int e_lat,
                             input int e_gcd, input int e_n, input logic [15:0] e_seq,
                             input int e_iter, input int inj, input logic [3:0] a,
                             input logic [3:0] b);
        int term, lat, gcdv, nsub;
        logic [15:0] seq;
        logic bad, rdy;
        run_op(a, b, inj, term, lat, gcdv, nsub, seq, bad, rdy);
        chk({tag, " term"}, term, e_term);
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " subtracts"}, nsub, e_n);
        chk({tag, " sel seq"}, int'(seq), int'(e_seq));
        chk({tag, " iter"}, int'(iter), e_iter);
        chk({tag, " invariants"}, int'(bad), 0);
        chk({tag, " ready after"}, int'(rdy), 1);
        if (e_term == 1) chk({tag, " gcd"}, gcdv, e_gcd);
    endtask

    initial begin
        int e_term, e_lat, e_g, e_n, e_it;
        logic [15:0] e_seq;
        logic any_pulse;

        vecs[0] = '{4'd12, 4'd8,  1, 5,  4, 2,  16'h0001};
        vecs[1] = '{4'd7,  4'd7,  1, 3,  7, 0,  16'h0000};
        vecs[2] = '{4'd15, 4'd1,  1, 17, 1, 14, 16'h3FFF};
        vecs[3] = '{4'd0,  4'd5,  2, 1,  0, -1, 16'h0000};
        vecs[4] = '{4'd9,  4'd6,  1, 5,  3, 2,  16'h0001};
        vecs[5] = '{4'd5,  4'd0,  2, 1,  0, -1, 16'h0000};
        vecs[6] = '{4'd1,  4'd15, 1, 17, 1, 14, 16'h0000};

        // Reset with start held high: reset must win.
        rst = 1'b1; start = 1'b1; data_A = 4'd3; data_B = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", int'({ready, ldA, ldB, sel, out, strt, done, err, iter}), 12'h800);
        start = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            e_n = 0;
            for (int s = 0; s < 16; s++) if (vecs[i].sel_seq[s]) e_n++;
            if (vecs[i].term == 1) e_n = vecs[i].lat - 3;
            e_it = (vecs[i].it < 0) ? exp_iter_hold : vecs[i].it;
            check_run($sformatf("vec%0d", i), vecs[i].term, vecs[i].lat, vecs[i].gcd,
                      e_n, vecs[i].sel_seq, e_it, 0, vecs[i].a, vecs[i].b);
            if (vecs[i].it >= 0) exp_iter_hold = vecs[i].it;
        end

        // Forced lt=1/eq=0: 15 subtracts, timeout cycle without strt, then err.
        force_lt = 1'b1;
        check_run("timeout", 2, 18, 0, 15, 16'h0000, 15, 0, 4'd3, 4'd5);
        force_lt = 1'b0;
        exp_iter_hold = 15;

        // Reset in the middle of CALC for (15,1).
        @(negedge clk);
        data_A = 4'd15; data_B = 4'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid-run reset outputs",
            int'({ready, ldA, ldB, sel, out, strt, done, err, iter}), 12'h800);
        rst = 1'b0;
        any_pulse = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || err || !ready) any_pulse = 1'b1;
        end
        chk("no pulse after abort", int'(any_pulse), 0);
        exp_iter_hold = 0;

        // Fresh run after abort, with a stray start during CALC.
        check_run("start ignored", 1, 5, 4, 2, 16'h0001, 2, 3, 4'd12, 4'd8);
        exp_iter_hold = 2;

        // Random operands against the reference model.
        for (int r = 0; r < 40; r++) begin
            logic [3:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            ref_gcd(int'(ra), int'(rb), e_term, e_lat, e_g, e_n, e_seq);
            e_it = (ra == 0 || rb == 0) ? exp_iter_hold : e_n;
            check_run($sformatf("rand%0d(%0d,%0d)", r, ra, rb), e_term, e_lat, e_g,
                      e_n, e_seq, e_it, 0, ra, rb);
            exp_iter_hold = e_it;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
